dma_copier: RTL and testbench

Memory-to-memory copy engine that acts as the requester on the `memory_if` bus, directly upstream of the shared `memory` block. It accepts a (source, destination, length) command. It then moves data in bursts: it reads up to `BURST` words into an internal buffer, then writes them back out, and repeats until the length is exhausted. Status is reported through a `busy` level and a one-cycle `done` pulse.

---
 rtl/dma_pkg.sv | 25 ++
 rtl/memory_if.sv | 15 +
 rtl/dma_copier_buffer.sv | 71 +++++++
 rtl/dma_copier.sv | 209 ++++++++++++++++++++
 tb/tb_dma_copier.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared types for the dma_copier memory-to-memory copy engine.
// Holds the word/address/length types, the FSM state enum and an address-step helper.
package dma_pkg;

    typedef logic [7:0] word_t;
    typedef logic [7:0] addr_t;
    typedef logic [8:0] len_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    // Addresses wrap modulo 256 in either direction.
    function automatic addr_t step_addr(input addr_t a, input logic back);
        if (back) begin
            return a - 8'd1;
        end else begin
            return a + 8'd1;
        end
    endfunction

endpackage

// File: rtl/memory_if.sv
// Requester/memory handshake bus shared by dma_copier and the memory block.
// Read data is combinational: it is valid in the same cycle as ren && ready.
interface memory_if;
    logic       ren;
    logic       wen;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ready;

    modport request (output ren, output wen, output addr, output wdata,
                     input rdata, input ready);
    modport memory  (input ren, input wen, input addr, input wdata,
                     output rdata, output ready);
endinterface

// File: rtl/dma_copier_buffer.sv
// copy_buffer: DEPTH-deep word FIFO holding one burst between its read and write phases.
// next_head exposes the entry behind the head so the owner can register wdata ahead of a pop.
module copy_buffer
    import dma_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [7:0]    next_head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    word_t          mem_r [DEPTH];
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [CW-1:0]  count_r;
    logic           do_push_s;
    logic           do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage, pointers and occupancy; reset flushes everything to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count     = count_r;
    assign empty     = (count_r == {CW{1'b0}});
    assign full      = (count_r == CW'(DEPTH));
    assign head      = empty ? 8'h00 : mem_r[rd_ptr_r];
    assign next_head = mem_r[ptr_inc(rd_ptr_r)];

endmodule

// File: rtl/dma_copier.sv
// dma_copier: burst memory-to-memory copy engine, requester side of memory_if.
// Optional macro DMA_OVERLAP_EN enables backward copying for overlapping ranges (memmove).
module dma_copier
    import dma_pkg::*;
#(
    parameter int BURST = 4,
    localparam int CW = $clog2(BURST + 1)
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         start,
    input  logic [7:0]   src,
    input  logic [7:0]   dst,
    input  logic [8:0]   len,
    output logic         busy,
    output logic         done,
    memory_if.request    memif
);

    dma_state_t     state_r;
    dma_state_t     next_state_s;
    addr_t          src_r;
    addr_t          dst_r;
    len_t           rem_r;
    logic           back_r;

    logic           back_s;
    addr_t          start_src_s;
    addr_t          start_dst_s;
    addr_t          next_src_s;
    addr_t          next_dst_s;
    logic           rd_fire_s;
    logic           wr_fire_s;

    word_t          buf_head_s;
    word_t          buf_next_head_s;
    logic [CW-1:0]  buf_count_s;
    logic           buf_empty_s;
    logic           buf_full_s;

    logic           ren_s;
    logic           wen_s;
    logic           busy_s;
    logic           done_s;
    addr_t          addr_s;
    word_t          wdata_s;
    logic           ren_r;
    logic           wen_r;
    logic           busy_r;
    logic           done_r;
    addr_t          addr_r;
    word_t          wdata_r;

    assign rd_fire_s = (state_r == READ)  && memif.ready;
    assign wr_fire_s = (state_r == WRITE) && memif.ready;

    copy_buffer #(.DEPTH(BURST)) u_buffer (
        .clk       (CLK),
        .rst_n     (nRST),
        .push      (rd_fire_s),
        .push_data (memif.rdata),
        .pop       (wr_fire_s),
        .head      (buf_head_s),
        .next_head (buf_next_head_s),
        .count     (buf_count_s),
        .empty     (buf_empty_s),
        .full      (buf_full_s)
    );

`ifdef DMA_OVERLAP_EN
    addr_t dist_s;
`endif

    // Direction and starting addresses for a command presented on src/dst/len.
    always_comb begin
`ifdef DMA_OVERLAP_EN
        dist_s = dst - src;
        back_s = (dist_s != 8'h00) && ({1'b0, dist_s} < len);
`else
        back_s = 1'b0;
`endif
        if (back_s) begin
            start_src_s = src + len[7:0] - 8'd1;
            start_dst_s = dst + len[7:0] - 8'd1;
        end else begin
            start_src_s = src;
            start_dst_s = dst;
        end
    end

    // Address stepping: an address only moves when its access completes.
    always_comb begin
        if (state_r == IDLE) begin
            next_src_s = start_src_s;
            next_dst_s = start_dst_s;
        end else begin
            next_src_s = rd_fire_s ? step_addr(src_r, back_r) : src_r;
            next_dst_s = wr_fire_s ? step_addr(dst_r, back_r) : dst_r;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; ready low stalls every transition out of READ/WRITE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = (len == 9'd0) ? DONE : READ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ: begin
                if (rd_fire_s && (buf_count_s == CW'(BURST - 1) || rem_r == 9'd1 || buf_full_s)) begin
                    next_state_s = WRITE;
                end else begin
                    next_state_s = READ;
                end
            end
            WRITE: begin
                if (wr_fire_s && buf_count_s == CW'(1)) begin
                    next_state_s = (rem_r != 9'd0) ? READ : DONE;
                end else begin
                    next_state_s = WRITE;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output lookahead: values the bus and status pins take in the next state.
    always_comb begin
        ren_s  = (next_state_s == READ);
        wen_s  = (next_state_s == WRITE);
        busy_s = (next_state_s != IDLE);
        done_s = (next_state_s == DONE);
        case (next_state_s)
            READ:    addr_s = next_src_s;
            WRITE:   addr_s = next_dst_s;
            default: addr_s = 8'h00;
        endcase
        if (next_state_s == WRITE) begin
            if (state_r == WRITE) begin
                wdata_s = wr_fire_s ? buf_next_head_s : buf_head_s;
            end else begin
                // Entering WRITE: a burst of one word has its data only on rdata so far.
                wdata_s = buf_empty_s ? memif.rdata : buf_head_s;
            end
        end else begin
            wdata_s = 8'h00;
        end
    end

    // Copy progress registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            src_r  <= 8'h00;
            dst_r  <= 8'h00;
            rem_r  <= 9'd0;
            back_r <= 1'b0;
        end else begin
            src_r <= next_src_s;
            dst_r <= next_dst_s;
            if (state_r == IDLE) begin
                rem_r  <= len;
                back_r <= back_s;
            end else if (rd_fire_s) begin
                rem_r <= rem_r - 9'd1;
            end
        end
    end

    // Registered bus and status outputs.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ren_r   <= 1'b0;
            wen_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            addr_r  <= 8'h00;
            wdata_r <= 8'h00;
        end else begin
            ren_r   <= ren_s;
            wen_r   <= wen_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
        end
    end

    assign memif.ren   = ren_r;
    assign memif.wen   = wen_r;
    assign memif.addr  = addr_r;
    assign memif.wdata = wdata_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_dma_copier.sv
// Self-checking bench for dma_copier: memory model, write scoreboard and scenario tasks.
// Build with DMA_OVERLAP_EN defined to also exercise the overlapping-copy scenario.
module tb_dma_copier;
    localparam int BURST = 4;

    logic       clk;
    logic       nrst;
    logic       start;
    logic [7:0] src;
    logic [7:0] dst;
    logic [8:0] len;
    logic       busy;
    logic       done;

    memory_if mif();

    dma_copier #(.BURST(BURST)) dut (
        .CLK   (clk),
        .nRST  (nrst),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .memif (mif)
    );

    logic [7:0] mem [256];
    logic       ready_drv;
    logic       poke_en;
    logic [7:0] poke_addr;
    logic [7:0] poke_data;
    logic [15:0] exp_q [$];
    int vectors = 0;
    int errors  = 0;
    int ren_cnt = 0;
    int wen_cnt = 0;

    assign mif.ready = ready_drv;
    assign mif.rdata = mem[mif.addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mif.wen && mif.ready) mem[mif.addr] <= mif.wdata;
        else if (poke_en)         mem[poke_addr] <= poke_data;
    end

    // Write scoreboard: every completed write must match the next expected (addr, data).
    always @(negedge clk) begin : monitor
        logic [15:0] e;
        if (mif.ren) ren_cnt++;
        if (mif.wen) wen_cnt++;
        if (mif.ren && mif.wen) begin
            errors++;
            $display("FAIL ren_wen_both: ren=%b wen=%b, required not both", mif.ren, mif.wen);
        end
        if (mif.wen && mif.ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: write addr=%h data=%h, required no write", mif.addr, mif.wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mif.addr, mif.wdata} !== e) begin
                    errors++;
                    $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                             mif.addr, mif.wdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Reference model of the write sequence, taken from the memory before the copy starts.
    task automatic expect_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n);
        logic       back;
        logic [7:0] off;
        back = 1'b0;
`ifdef DMA_OVERLAP_EN
        begin
            logic [7:0] dist;
            dist = d - s;
            back = (dist != 8'h00) && ({1'b0, dist} < n);
        end
`endif
        for (int i = 0; i < int'(n); i++) begin
            off = back ? 8'(int'(n) - 1 - i) : 8'(i);
            exp_q.push_back({d + off, mem[s + off]});
        end
    endtask

    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n,
                            input int stall_k, output int done_k);
        logic [7:0] h_addr;
        logic [7:0] h_data;
        h_addr = 8'h00; h_data = 8'h00;
        expect_copy(s, d, n);
        start = 1'b1; src = s; dst = d; len = n;
        @(posedge clk); #1;
        start = 1'b0;
        done_k = -1;
        for (int k = 1; k <= 1200; k++) begin
            if (stall_k > 0 && k >= stall_k && k < stall_k + 3) begin
                ready_drv = 1'b0;
                vectors++;
                if (k == stall_k) begin
                    h_addr = mif.addr; h_data = mif.wdata;
                    if (mif.wen !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_in_write: wen=%b, required 1", mif.wen);
                    end
                end else if (mif.addr !== h_addr || mif.wdata !== h_data) begin
                    errors++;
                    $display("FAIL stall_hold: addr=%h wdata=%h, required addr=%h wdata=%h",
                             mif.addr, mif.wdata, h_addr, h_data);
                end
            end else begin
                ready_drv = 1'b1;
            end
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        ready_drv = 1'b1;
        if (done_k < 0) begin
            vectors++; errors++;
            $display("FAIL copy_timeout: done never seen, required within 1200 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; start = 1'b0; src = 8'h00; dst = 8'h00; len = 9'd0; ready_drv = 1'b1;
        for (int i = 0; i < 256; i++) poke(8'(i), 8'(i * 7 + 3));
        vectors++;
        if ({busy, done, mif.ren, mif.wen, mif.addr, mif.wdata} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b ren=%b wen=%b addr=%h wdata=%h, required all 0",
                     busy, done, mif.ren, mif.wen, mif.addr, mif.wdata);
        end
        nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int k;
        for (int i = 0; i < 8; i++) poke(8'h10 + 8'(i), 8'hA0 + 8'(i));
        run_copy(8'h10, 8'h80, 9'd8, 0, k);
        vectors++;
        if (k != 17) begin errors++; $display("FAIL basic_done_cycle: %0d, required 17", k); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (mem[8'h80 + 8'(i)] !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL basic_data[%0d]: %h, required %h", i, mem[8'h80 + 8'(i)], 8'hA0 + 8'(i));
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_sb_left: %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_len_zero();
        logic [7:0] snap [256];
        int k;
        int diffs;
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        ren_cnt = 0; wen_cnt = 0;
        run_copy(8'h30, 8'h50, 9'd0, 0, k);
        vectors++;
        if (k != 1) begin errors++; $display("FAIL len0_done_cycle: %0d, required 1", k); end
        vectors++;
        if (ren_cnt != 0 || wen_cnt != 0) begin
            errors++;
            $display("FAIL len0_access: ren cycles=%0d wen cycles=%0d, required 0 and 0", ren_cnt, wen_cnt);
        end
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) diffs++;
        vectors++;
        if (diffs != 0) begin errors++; $display("FAIL len0_memory: %0d words changed, required 0", diffs); end
    endtask

    task automatic test_wrap();
        int k;
        for (int i = 0; i < 4; i++) poke(8'hFE + 8'(i), 8'(i + 1));
        run_copy(8'hFE, 8'h40, 9'd4, 0, k);
        vectors++;
        if (k != 9) begin errors++; $display("FAIL wrap_done_cycle: %0d, required 9", k); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem[8'h40 + 8'(i)] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL wrap_data[%0d]: %h, required %h", i, mem[8'h40 + 8'(i)], 8'(i + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        for (int i = 0; i < 8; i++) poke(8'h60 + 8'(i), 8'h31 + 8'(i));
        run_copy(8'h60, 8'hA0, 9'd8, 6, k);
        vectors++;
        if (k != 20) begin errors++; $display("FAIL bp_done_cycle: %0d, required 20", k); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (mem[8'hA0 + 8'(i)] !== 8'h31 + 8'(i)) begin
                errors++;
                $display("FAIL bp_data[%0d]: %h, required %h", i, mem[8'hA0 + 8'(i)], 8'h31 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) poke(8'h90 + 8'(i), 8'hEE);
        expect_copy(8'h10, 8'h90, 9'd8);
        start = 1'b1; src = 8'h10; dst = 8'h90; len = 9'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 9; k++) begin @(posedge clk); #1; end
        vectors++;
        if (mif.ren !== 1'b1 || mif.addr !== 8'h14) begin
            errors++;
            $display("FAIL mid_second_read: ren=%b addr=%h, required 1 and 14", mif.ren, mif.addr);
        end
        nrst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({busy, done, mif.ren, mif.wen, mif.addr, mif.wdata} !== 20'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b ren=%b wen=%b addr=%h wdata=%h, required all 0",
                     busy, done, mif.ren, mif.wen, mif.addr, mif.wdata);
        end
        nrst = 1'b1;
        exp_q.delete();
        ren_cnt = 0; wen_cnt = 0;
        for (int k = 0; k < 12; k++) begin @(posedge clk); #1; end
        vectors++;
        if (ren_cnt != 0 || wen_cnt != 0) begin
            errors++;
            $display("FAIL mid_after_reset: ren cycles=%0d wen cycles=%0d, required 0 and 0", ren_cnt, wen_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (mem[8'h90 + 8'(i)] !== ((i < 4) ? 8'hA0 + 8'(i) : 8'hEE)) begin
                errors++;
                $display("FAIL mid_data[%0d]: %h, required %h", i, mem[8'h90 + 8'(i)],
                         (i < 4) ? 8'hA0 + 8'(i) : 8'hEE);
            end
        end
    endtask

    task automatic test_back_to_back();
        poke(8'hC0, 8'h5A); poke(8'hC1, 8'h5B); poke(8'hD0, 8'h00); poke(8'hD1, 8'h00);
        expect_copy(8'hC0, 8'hD0, 9'd2);
        expect_copy(8'hC0, 8'hD0, 9'd2);
        start = 1'b1; src = 8'hC0; dst = 8'hD0; len = 9'd2;
        @(posedge clk); #1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 5 || k == 11) begin
                vectors++;
                if (done !== 1'b1) begin errors++; $display("FAIL b2b_done@%0d: %b, required 1", k, done); end
            end
            if (k == 6) begin
                vectors++;
                if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy=%b, required 0", busy); end
            end
            if (k == 7) begin
                vectors++;
                if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: busy=%b, required 1", busy); end
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (mem[8'hD0] !== 8'h5A || mem[8'hD1] !== 8'h5B || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_data: %h %h left=%0d, required 5a 5b left=0", mem[8'hD0], mem[8'hD1], exp_q.size());
        end
    endtask

    task automatic test_full_space();
        int k;
        run_copy(8'h33, 8'h33, 9'd256, 0, k);
        vectors++;
        if (k != 513 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_space: done cycle=%0d left=%0d, required 513 and 0", k, exp_q.size());
        end
    endtask

`ifdef DMA_OVERLAP_EN
    task automatic test_overlap();
        int k;
        for (int i = 0; i < 6; i++) poke(8'h20 + 8'(i), 8'(i));
        run_copy(8'h20, 8'h22, 9'd6, 0, k);
        vectors++;
        if (k != 13) begin errors++; $display("FAIL overlap_done_cycle: %0d, required 13", k); end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (mem[8'h22 + 8'(i)] !== 8'(i)) begin
                errors++;
                $display("FAIL overlap_data[%0d]: %h, required %h", i, mem[8'h22 + 8'(i)], 8'(i));
            end
        end
    endtask
`endif

    initial begin
        poke_en = 1'b0; poke_addr = 8'h00; poke_data = 8'h00;
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_full_space();
`ifdef DMA_OVERLAP_EN
        test_overlap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
